// File: rtl/instr_decode_queue_pkg.sv
// Shared decode definitions for the instruction decode queue and any other
// consumer of MIPS-format fields (e.g. the hazard unit).
// Contents: instruction type encodings, field bit positions and widths,
// the jump opcodes and a 16-to-32 bit sign-extension helper.
package decode_pkg;

    typedef enum logic [1:0] {
        TYPE_R = 2'd0,
        TYPE_I = 2'd1,
        TYPE_J = 2'd2
    } instr_type_e;

    // Field LSB positions within a 32-bit instruction word
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_LSB = 0;

    // Field widths
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_J     = 6'd2;
    localparam logic [5:0] OPC_JAL   = 6'd3;

    function automatic logic [31:0] sign_extend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// Bundle of the fetch-side and execute-side signals of the decode queue.
// slave  : the queue itself (accepts words, drives decoded head fields)
// master : the environment (fetch + execute + redirect logic)
// Fetch side  : in_instr, in_valid, in_ready, flush
// Execute side: out_ready, out_valid, decoded fields, out_type, out_instr
interface instr_decode_queue_if;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [31:0] out_imm;
    logic [25:0] out_target;
    logic [1:0]  out_type;
    logic [31:0] out_instr;

    modport slave (
        input  in_instr, in_valid, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm, out_target, out_type, out_instr
    );

    modport master (
        output in_instr, in_valid, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm, out_target, out_type, out_instr
    );
endinterface

// File: rtl/instr_decode_queue_field_decode.sv
// instr_field_decode: purely combinational split of a 32-bit MIPS word into
// its fields, a sign-extended immediate and an R/I/J type tag.
// Ports: instr (in, 32) -> opcode, rs, rt, rd, shamt, funct, imm (32),
//        target (26), instr_type (2: 0=R, 1=I, 2=J; 3 never produced).
module instr_field_decode
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm,
    output logic [25:0] target,
    output logic [1:0]  instr_type
);

    instr_type_e type_s;

    assign opcode = instr[OPCODE_LSB +: OPCODE_W];
    assign rs     = instr[RS_LSB     +: REG_W];
    assign rt     = instr[RT_LSB     +: REG_W];
    assign rd     = instr[RD_LSB     +: REG_W];
    assign shamt  = instr[SHAMT_LSB  +: REG_W];
    assign funct  = instr[FUNCT_LSB  +: FUNCT_W];
    assign imm    = sign_extend16(instr[IMM_LSB +: IMM_W]);
    assign target = instr[TARGET_LSB +: TARGET_W];
    assign instr_type = type_s;

    // Classify by opcode: 0 is R-type, j/jal are J-type, everything else I-type
    always_comb begin
        type_s = TYPE_I;
        case (opcode)
            OPC_RTYPE:      type_s = TYPE_R;
            OPC_J, OPC_JAL: type_s = TYPE_J;
            default:        type_s = TYPE_I;
        endcase
    end

endmodule

// File: rtl/instr_decode_queue.sv
// instr_decode_queue: DEPTH-entry circular buffer between fetch and execute.
// Presents the head word decoded into MIPS fields; all outputs are zero
// while the queue is empty. in_ready depends only on the registered count,
// so there is no combinational path from out_ready to in_ready.
// Ports: clk, rst (async, active-high), bus (instr_decode_queue_if.slave).
module instr_decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    instr_decode_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ZERO_COUNT = {(AW + 1){1'b0}};
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   head_s;

    assign bus.in_ready  = (count_r != FULL_COUNT);
    assign bus.out_valid = (count_r != ZERO_COUNT);
    assign push_s        = bus.in_valid && bus.in_ready;
    assign pop_s         = bus.out_valid && bus.out_ready;

    // Stale array contents must not leak out once the queue has drained
    assign head_s        = bus.out_valid ? mem_r[rd_ptr_r] : 32'h0000_0000;
    assign bus.out_instr = head_s;

    // Entry storage; a flushed cycle's offered word is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s && !bus.flush) begin
            mem_r[wr_ptr_r] <= bus.in_instr;
        end
    end

    // Pointer and occupancy control; flush overrides push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= ZERO_COUNT;
        end else if (bus.flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= ZERO_COUNT;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    instr_field_decode u_decode (
        .instr      (head_s),
        .opcode     (bus.out_opcode),
        .rs         (bus.out_rs),
        .rt         (bus.out_rt),
        .rd         (bus.out_rd),
        .shamt      (bus.out_shamt),
        .funct      (bus.out_funct),
        .imm        (bus.out_imm),
        .target     (bus.out_target),
        .instr_type (bus.out_type)
    );

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue (DEPTH = 2).
module tb_instr_decode_queue;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    instr_decode_queue_if bus ();

    instr_decode_queue #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_instr = 32'h0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        #2;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h exp 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0h exp 1", bus.in_ready); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr got %08h exp 0", bus.out_instr); end
        n_cmp++; if (bus.out_imm !== 32'h0) begin n_err++; $display("FAIL reset_out_imm got %08h exp 0", bus.out_imm); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_r_type();
        bus.in_instr = 32'h012A4020; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL r_valid got %0h exp 1", bus.out_valid); end
        n_cmp++; if (bus.out_opcode !== 6'd0) begin n_err++; $display("FAIL r_opcode got %0h exp 0", bus.out_opcode); end
        n_cmp++; if (bus.out_rs !== 5'd9) begin n_err++; $display("FAIL r_rs got %0d exp 9", bus.out_rs); end
        n_cmp++; if (bus.out_rt !== 5'd10) begin n_err++; $display("FAIL r_rt got %0d exp 10", bus.out_rt); end
        n_cmp++; if (bus.out_rd !== 5'd8) begin n_err++; $display("FAIL r_rd got %0d exp 8", bus.out_rd); end
        n_cmp++; if (bus.out_shamt !== 5'd0) begin n_err++; $display("FAIL r_shamt got %0d exp 0", bus.out_shamt); end
        n_cmp++; if (bus.out_funct !== 6'h20) begin n_err++; $display("FAIL r_funct got %0h exp 20", bus.out_funct); end
        n_cmp++; if (bus.out_type !== 2'd0) begin n_err++; $display("FAIL r_type got %0d exp 0", bus.out_type); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL r_drain_valid got %0h exp 0", bus.out_valid); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL r_drain_instr got %08h exp 0", bus.out_instr); end
    endtask

    task automatic test_back_to_back();
        bus.in_instr = 32'h8D090004; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_opcode !== 6'h23) begin n_err++; $display("FAIL b2b_op1 got %0h exp 23", bus.out_opcode); end
        n_cmp++; if (bus.out_rs !== 5'd8) begin n_err++; $display("FAIL b2b_rs1 got %0d exp 8", bus.out_rs); end
        n_cmp++; if (bus.out_rt !== 5'd9) begin n_err++; $display("FAIL b2b_rt1 got %0d exp 9", bus.out_rt); end
        n_cmp++; if (bus.out_imm !== 32'h00000004) begin n_err++; $display("FAIL b2b_imm1 got %08h exp 00000004", bus.out_imm); end
        n_cmp++; if (bus.out_type !== 2'd1) begin n_err++; $display("FAIL b2b_type1 got %0d exp 1", bus.out_type); end
        bus.in_instr = 32'h2108FFFF;
        tick();
        n_cmp++; if (bus.out_instr !== 32'h2108FFFF) begin n_err++; $display("FAIL b2b_instr2 got %08h exp 2108ffff", bus.out_instr); end
        n_cmp++; if (bus.out_opcode !== 6'h08) begin n_err++; $display("FAIL b2b_op2 got %0h exp 08", bus.out_opcode); end
        n_cmp++; if (bus.out_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b_imm2 got %08h exp ffffffff", bus.out_imm); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %0h exp 1", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_full_wrap();
        bus.in_instr = 32'h08000010; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        n_cmp++; if (bus.out_type !== 2'd2) begin n_err++; $display("FAIL full_type_j got %0d exp 2", bus.out_type); end
        n_cmp++; if (bus.out_target !== 26'h0000010) begin n_err++; $display("FAIL full_target got %07h exp 0000010", bus.out_target); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1 got %0h exp 1", bus.in_ready); end
        bus.in_instr = 32'h0C000020;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready2 got %0h exp 0", bus.in_ready); end
        bus.in_instr = 32'hDEADBEEF;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready3 got %0h exp 0", bus.in_ready); end
        n_cmp++; if (bus.out_instr !== 32'h08000010) begin n_err++; $display("FAIL full_head_kept got %08h exp 08000010", bus.out_instr); end
        // Pop on a full queue: the offered word must not enter this cycle
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_instr !== 32'h0C000020) begin n_err++; $display("FAIL full_pop1 got %08h exp 0c000020", bus.out_instr); end
        n_cmp++; if (bus.out_type !== 2'd2) begin n_err++; $display("FAIL full_type_jal got %0d exp 2", bus.out_type); end
        n_cmp++; if (bus.out_target !== 26'h0000020) begin n_err++; $display("FAIL full_target2 got %07h exp 0000020", bus.out_target); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready4 got %0h exp 1", bus.in_ready); end
        tick();
        n_cmp++; if (bus.out_instr !== 32'hDEADBEEF) begin n_err++; $display("FAIL full_pop2 got %08h exp deadbeef", bus.out_instr); end
        n_cmp++; if (bus.out_opcode !== 6'h37) begin n_err++; $display("FAIL full_op3 got %0h exp 37", bus.out_opcode); end
        n_cmp++; if (bus.out_type !== 2'd1) begin n_err++; $display("FAIL full_type3 got %0d exp 1", bus.out_type); end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL full_drain got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.in_instr = 32'h11111111;
        tick();
        bus.in_instr = 32'h22222222;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre_full got %0h exp 0", bus.in_ready); end
        bus.flush = 1'b1; bus.in_instr = 32'h33333333; bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0h exp 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0h exp 1", bus.in_ready); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL flush_instr got %08h exp 0", bus.out_instr); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_offered got %0h exp 0", bus.out_valid); end
        // NOP is a real instruction after flush
        bus.in_instr = 32'h00000000; bus.in_valid = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL nop_valid got %0h exp 1", bus.out_valid); end
        n_cmp++; if (bus.out_type !== 2'd0) begin n_err++; $display("FAIL nop_type got %0d exp 0", bus.out_type); end
        n_cmp++; if (bus.out_funct !== 6'd0) begin n_err++; $display("FAIL nop_funct got %0h exp 0", bus.out_funct); end
        bus.in_instr = 32'h012A4020;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL nop_full got %0h exp 0", bus.in_ready); end
    endtask

    task automatic test_async_reset();
        // Queue is full here; assert rst well away from any rising edge
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %0h exp 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got %0h exp 1", bus.in_ready); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL arst_instr got %08h exp 0", bus.out_instr); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_after got %0h exp 0", bus.out_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_r_type();
        test_back_to_back();
        test_full_wrap();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Decode-side instruction buffer sitting directly downstream of the instruction fetch stage. Accepts 32-bit instruction words from fetch through a valid/ready handshake, holds them in a small circular queue, and presents the head entry to the execute stage split into MIPS-format fields with a sign-extended immediate and an R/I/J type tag. Provides backpressure to fetch and a single-cycle flush for branch redirects.

## Interface
- DEPTH, 2, queue entries; power of two, at least 2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_instr  input  32  instruction word from fetch
- in_valid  input  1  in_instr is valid this cycle
- in_ready  output  1  queue can accept a word this cycle
- flush  input  1  discard all queued entries (branch redirect)
- out_ready  input  1  execute stage consumes the head entry this cycle
- out_valid  output  1  head entry present
- out_opcode  output  6  instr[31:26]
- out_rs  output  5  instr[25:21]
- out_rt  output  5  instr[20:16]
- out_rd  output  5  instr[15:11]
- out_shamt  output  5  instr[10:6]
- out_funct  output  6  instr[5:0]
- out_imm  output  32  instr[15:0] sign-extended
- out_target  output  26  instr[25:0]
- out_type  output  2  0 = R, 1 = I, 2 = J
- out_instr  output  32  raw head word

## Operation
- Storage: DEPTH x 32 entry array, write pointer, read pointer, count (0..DEPTH).
- Push: in_valid && in_ready. Writes in_instr at the write pointer, then increments the write pointer.
- Pop: out_valid && out_ready. Increments the read pointer.
- Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). Depends only on registered state; no combinational path from out_ready.
- out_valid = (count != 0).
- Push and pop in the same cycle leave count unchanged.
- Full queue: in_ready = 0, so no push occurs. A pop on a full queue frees the slot for the next cycle only. No pass-through.
- Flush: on the next edge, count, write pointer and read pointer all go to 0. Flush has priority over any push and pop in the same cycle; the word offered that cycle is dropped.
- Decode is combinational from the head entry:
  - opcode 0 gives type R.
  - opcode 2 or 3 gives type J.
  - every other opcode gives type I.
  - type 3 is never produced.
- When out_valid = 0, all decoded outputs and out_instr are 0.
- Word 0x00000000 (NOP) is queued and presented like any other word: type R, funct 0.

## Timing
- Reset: count = 0, both pointers = 0, array cleared to 0.
- Output values during reset: out_valid = 0, in_ready = 1, all field outputs 0.
- Latency: a word pushed at edge N into an empty queue gives out_valid = 1 with its fields after edge N.
- Back-to-back throughput is one word per cycle while out_ready is held high.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Queued words are lost.
- After flush at edge N: out_valid = 0 and in_ready = 1 following edge N.

## Structure
- Shared package `decode_pkg`:
  - instruction type encodings (R/I/J)
  - field bit-position constants
  - J opcodes 2/3
- Sub-module `instr_field_decode`: combinational split of a 32-bit word into fields, sign extension and type. It is reused later by the hazard unit.
- Queue control and storage stay in the top module.

## Test plan
- Reset, then push 0x012A4020 with out_ready = 0. Next cycle: out_valid = 1, opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20, type R.
- Push 0x8D090004 and 0x2108FFFF back-to-back with out_ready = 1.
  - First word: opcode 0x23, rs 8, rt 9, imm 0x00000004, type I.
  - Second word: opcode 0x08, imm 0xFFFFFFFF.
- Push 0x08000010, then hold out_ready = 0 and keep in_valid = 1.
  - Head shows type J, target 0x0000010.
  - in_ready drops to 0 after DEPTH words; no further words are lost or overwritten.
  - Pop order matches push order across pointer wrap.
- With 2 entries queued, assert flush, in_valid and out_ready together. Next cycle: out_valid = 0, count 0, offered word absent.
- Assert rst asynchronously between edges with the queue full. out_valid drops to 0 and in_ready rises to 1 without a clock edge.
